// File: rtl/seg7_bus_if.sv
// CPU memory-bus write channel that feeds the seven-segment display port.
interface seg7_bus_if;
   logic        memory_w;
   logic [15:0] addr;
   logic [15:0] cpu_data;

   modport master (output memory_w, output addr, output cpu_data);
   modport slave  (input  memory_w, input  addr, input  cpu_data);
endinterface

// File: rtl/seg7_port_reg.sv
// Memory-mapped display port. Shows the last data write as raw hex, or as four
// BCD digits produced by a sequential double-dabble converter.
module seg7_port_reg #(
   parameter logic [15:0] DATA_ADDR = 16'hFFF0,
   parameter logic [15:0] CTRL_ADDR = 16'hFFF1
) (
   input  logic             clk,
   input  logic             rst,
   seg7_bus_if.slave        bus,
   output logic [15:0]      disp_value,
   output logic             busy,
   output logic             ovf
);

   localparam int unsigned VAL_W = 16;
   localparam int unsigned SH_W  = 36;
   localparam int unsigned CNT_W = 5;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SHIFT  = 2'd1;
   localparam logic [1:0] ST_COMMIT = 2'd2;

   logic [1:0]       state, state_nx;
   logic [VAL_W-1:0] raw, raw_nx;
   logic             mode, mode_nx;
   logic [SH_W-1:0]  sh, sh_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic [VAL_W-1:0] disp_nx;
   logic             busy_nx, ovf_nx;
   logic             start;
   logic [VAL_W-1:0] start_val;
   logic             data_wr_c, ctrl_wr_c;

   assign data_wr_c = bus.memory_w && (bus.addr == DATA_ADDR);
   assign ctrl_wr_c = bus.memory_w && (bus.addr == CTRL_ADDR);

   // One double-dabble step: +3 on every BCD nibble >= 5, then shift left.
   function automatic logic [SH_W-1:0] dabble_step(input logic [SH_W-1:0] s);
      logic [SH_W-1:0] t;
      t = s;
      for (int i = 0; i < 5; i++) begin
         if (t[16 + 4*i +: 4] >= 4'd5)
            t[16 + 4*i +: 4] = t[16 + 4*i +: 4] + 4'd3;
      end
      return {t[SH_W-2:0], 1'b0};
   endfunction

   // Next-state and registered-output logic; bus writes override FSM progress.
   always_comb begin
      state_nx  = state;
      raw_nx    = raw;
      mode_nx   = mode;
      sh_nx     = sh;
      cnt_nx    = cnt;
      disp_nx   = disp_value;
      busy_nx   = busy;
      ovf_nx    = ovf;
      start     = 1'b0;
      start_val = raw;

      case (state)
         ST_SHIFT: begin
            sh_nx  = dabble_step(sh);
            cnt_nx = cnt - CNT_W'(1);
            if (cnt == CNT_W'(1))
               state_nx = ST_COMMIT;
         end
         ST_COMMIT: begin
            if (sh[35:32] != 4'd0) begin
               disp_nx = 16'h9999;
               ovf_nx  = 1'b1;
            end else begin
               disp_nx = sh[31:16];
               ovf_nx  = 1'b0;
            end
            busy_nx  = 1'b0;
            state_nx = ST_IDLE;
         end
         default: ;
      endcase

      if (data_wr_c) begin
         raw_nx = bus.cpu_data;
         if (mode) begin
            start     = 1'b1;
            start_val = bus.cpu_data;
         end else begin
            disp_nx = bus.cpu_data;
            ovf_nx  = 1'b0;
         end
      end

      if (ctrl_wr_c) begin
         mode_nx = bus.cpu_data[0];
         if (bus.cpu_data[0]) begin
            start     = 1'b1;
            start_val = raw;
         end else begin
            disp_nx  = raw;
            ovf_nx   = 1'b0;
            busy_nx  = 1'b0;
            state_nx = ST_IDLE;
         end
      end

      // A start from any state discards in-flight work.
      if (start) begin
         sh_nx    = {20'd0, start_val};
         cnt_nx   = CNT_W'(16);
         busy_nx  = 1'b1;
         state_nx = ST_SHIFT;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         raw        <= '0;
         mode       <= 1'b0;
         sh         <= '0;
         cnt        <= '0;
         disp_value <= '0;
         busy       <= 1'b0;
         ovf        <= 1'b0;
      end else begin
         state      <= state_nx;
         raw        <= raw_nx;
         mode       <= mode_nx;
         sh         <= sh_nx;
         cnt        <= cnt_nx;
         disp_value <= disp_nx;
         busy       <= busy_nx;
         ovf        <= ovf_nx;
      end
   end

endmodule

// File: tb/tb_seg7_port_reg.sv
// Self-checking bench for seg7_port_reg: expected display results are queued
// when a write is issued and compared when the DUT commits.
module tb_seg7_port_reg;

   localparam logic [15:0] DATA_ADDR = 16'hFFF0;
   localparam logic [15:0] CTRL_ADDR = 16'hFFF1;

   typedef struct packed {
      logic [15:0] disp;
      logic        ovf;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [15:0] disp_value;
   logic        busy;
   logic        ovf;

   int n_checks = 0;
   int n_fail   = 0;
   exp_t q[$];

   seg7_bus_if bus ();

   seg7_port_reg dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus.slave),
      .disp_value (disp_value),
      .busy       (busy),
      .ovf        (ovf)
   );

   always #5 clk = ~clk;

   // Reference conversion using integer arithmetic.
   function automatic exp_t model(input logic [15:0] v);
      exp_t e;
      int   n;
      n = int'(v);
      if (n > 9999) begin
         e.disp = 16'h9999;
         e.ovf  = 1'b1;
      end else begin
         e.disp = {4'(n / 1000), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
         e.ovf  = 1'b0;
      end
      return e;
   endfunction

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Drives one bus cycle; returns #1 after the capturing edge.
   task automatic bus_cycle(input logic w, input logic [15:0] a, input logic [15:0] d);
      @(negedge clk);
      bus.memory_w = w;
      bus.addr     = a;
      bus.cpu_data = d;
      @(posedge clk);
      #1;
      bus.memory_w = 1'b0;
      bus.addr     = 16'h0000;
      bus.cpu_data = 16'h0000;
   endtask

   // Called right after the starting edge N; follows the conversion to N+17.
   task automatic track_conversion(input string name, input logic [15:0] prev);
      exp_t e;
      for (int i = 0; i <= 16; i++) begin
         if (i != 0) tick(1);
         n_checks++;
         if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL %s busy after edge N+%0d: got %b want 1", name, i, busy);
         end
         n_checks++;
         if (disp_value !== prev) begin
            n_fail++;
            $display("FAIL %s hold after edge N+%0d: got %h want %h", name, i, disp_value, prev);
         end
      end
      tick(1);
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL %s busy after commit: got %b want 0", name, busy);
      end
      if (q.size() == 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s scoreboard empty: got 0 entries want 1", name);
      end else begin
         e = q.pop_front();
         n_checks++;
         if (disp_value !== e.disp) begin
            n_fail++;
            $display("FAIL %s disp_value: got %h want %h", name, disp_value, e.disp);
         end
         n_checks++;
         if (ovf !== e.ovf) begin
            n_fail++;
            $display("FAIL %s ovf: got %b want %b", name, ovf, e.ovf);
         end
      end
   endtask

   task automatic check_idle(input string name, input logic [15:0] d, input logic o);
      n_checks++;
      if (disp_value !== d) begin
         n_fail++;
         $display("FAIL %s disp_value: got %h want %h", name, disp_value, d);
      end
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL %s busy: got %b want 0", name, busy);
      end
      n_checks++;
      if (ovf !== o) begin
         n_fail++;
         $display("FAIL %s ovf: got %b want %b", name, ovf, o);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      check_idle("reset", 16'h0000, 1'b0);
   endtask

   task automatic test_hex();
      exp_t e;
      q.push_back('{disp: 16'hDEF0, ovf: 1'b0});
      bus_cycle(1'b1, DATA_ADDR, 16'hDEF0);
      e = q.pop_front();
      check_idle("hex_write", e.disp, e.ovf);
   endtask

   task automatic test_decimal();
      // Switching to decimal converts the held raw value 0xDEF0 (57072).
      q.push_back(model(16'hDEF0));
      bus_cycle(1'b1, CTRL_ADDR, 16'h0001);
      track_conversion("mode_switch", 16'hDEF0);
      q.push_back(model(16'h04D2));
      bus_cycle(1'b1, DATA_ADDR, 16'h04D2);
      track_conversion("dec_1234", 16'h9999);
   endtask

   task automatic test_ovf();
      logic [15:0] vals [3];
      logic [15:0] prev;
      vals[0] = 16'd9999;
      vals[1] = 16'd10000;
      vals[2] = 16'hFFFF;
      prev = disp_value;
      for (int i = 0; i < 3; i++) begin
         q.push_back(model(vals[i]));
         bus_cycle(1'b1, DATA_ADDR, vals[i]);
         track_conversion($sformatf("ovf_%0d", i), prev);
         prev = 16'h9999;
      end
   endtask

   task automatic test_back_to_back();
      logic seen42;
      seen42 = 1'b0;
      bus_cycle(1'b1, DATA_ADDR, 16'd42);
      for (int i = 0; i < 4; i++) begin
         tick(1);
         if (disp_value === 16'h0042) seen42 = 1'b1;
      end
      q.push_back(model(16'd7));
      bus_cycle(1'b1, DATA_ADDR, 16'd7);
      track_conversion("restart", 16'h9999);
      n_checks++;
      if (seen42 !== 1'b0) begin
         n_fail++;
         $display("FAIL restart discarded value shown: got %b want 0", seen42);
      end
   endtask

   task automatic test_reset_mid();
      logic late;
      late = 1'b0;
      bus_cycle(1'b1, DATA_ADDR, 16'd5678);
      tick(7);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check_idle("reset_mid", 16'h0000, 1'b0);
      for (int i = 0; i < 20; i++) begin
         tick(1);
         if (disp_value !== 16'h0000 || busy !== 1'b0) late = 1'b1;
      end
      n_checks++;
      if (late !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid late commit: got disp %h busy %b want 0000 0", disp_value, busy);
      end
   endtask

   task automatic test_ignored();
      // Set decimal mode and display 0300.
      bus_cycle(1'b1, CTRL_ADDR, 16'h0001);
      tick(17);
      q.push_back(model(16'd300));
      bus_cycle(1'b1, DATA_ADDR, 16'd300);
      track_conversion("dec_300", 16'h0000);
      bus_cycle(1'b1, 16'hFFF2, 16'h1234);
      check_idle("other_addr", 16'h0300, 1'b0);
      bus_cycle(1'b0, DATA_ADDR, 16'h5555);
      check_idle("no_strobe", 16'h0300, 1'b0);
      // Raw must still be 300 (0x012C) if both writes were ignored.
      bus_cycle(1'b1, CTRL_ADDR, 16'h0000);
      check_idle("raw_intact", 16'd300, 1'b0);
      q.push_back(model(16'd300));
      bus_cycle(1'b1, CTRL_ADDR, 16'h0001);
      track_conversion("reconvert", 16'd300);
      bus_cycle(1'b1, DATA_ADDR, 16'h0456);
      tick(5);
      bus_cycle(1'b1, CTRL_ADDR, 16'h0000);
      check_idle("abort", 16'h0456, 1'b0);
      tick(20);
      check_idle("abort_settled", 16'h0456, 1'b0);
      // Hex mode again: one-edge latency.
      bus_cycle(1'b1, DATA_ADDR, 16'hA5C3);
      check_idle("hex_again", 16'hA5C3, 1'b0);
   endtask

   initial begin
      bus.memory_w = 1'b0;
      bus.addr     = 16'h0000;
      bus.cpu_data = 16'h0000;
      test_reset();
      test_hex();
      test_decimal();
      test_ovf();
      test_back_to_back();
      test_reset_mid();
      test_ignored();
      n_checks++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard leftover: got %0d entries want 0", q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
